// File: rtl/dtt_xbar_pkg.sv
// Shared crossbar types, widths and helpers.
// Used by the crossbar core and its egress buffers.
package dtt_xbar_pkg;

  localparam int DTT_DATA_WIDTH_DEF = 32;
  localparam int DTT_STAT_W         = 16;

  typedef logic [DTT_DATA_WIDTH_DEF-1:0] dtt_beat_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DTT_STAT_W-1:0] dtt_sat_inc(
    input logic [DTT_STAT_W-1:0] v
  );
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/dtt_sync_fifo.sv
// Synchronous FIFO: storage array, wrapping pointers, occupancy.
// Caller guarantees no push when full without pop, no pop when empty.
module dtt_sync_fifo
  import dtt_xbar_pkg::*;
#(
  parameter int WIDTH = DTT_DATA_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Next pointers and occupancy from this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/dtt_crossbar_egress.sv
// Per-output egress buffer for the crossbar; drops beats on overflow.
// Stats counters built only with DTT_EGRESS_STATS_EN defined.
module dtt_crossbar_egress
  import dtt_xbar_pkg::*;
#(
  parameter int DATA_WIDTH   = DTT_DATA_WIDTH_DEF,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   xbar_data,
  input  logic                    xbar_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic [DTT_STAT_W-1:0]   drop_count,
  output logic [DTT_STAT_W-1:0]   beat_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_THRESH);

  logic          pop;
  logic          push;
  logic          full;
  logic [LW-1:0] level_w;

  // Accept when space exists or a pop frees a slot this cycle.
  always_comb begin
    full = (level_w == DEPTH_L);
    pop  = m_valid && m_ready;
    push = xbar_valid && (!full || pop);
  end

  dtt_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (xbar_data),
    .rdata (m_data),
    .level (level_w)
  );

  assign level       = level_w;
  assign m_valid     = (level_w != '0);
  assign almost_full = (level_w >= AFULL_L);

`ifdef DTT_EGRESS_STATS_EN
  logic                  drop;
  logic [DTT_STAT_W-1:0] drop_q, drop_d;
  logic [DTT_STAT_W-1:0] beat_q, beat_d;

  // Saturating counts of accepted and discarded beats.
  always_comb begin
    drop   = xbar_valid && full && !pop;
    drop_d = drop_q;
    beat_d = beat_q;
    if (drop) drop_d = dtt_sat_inc(drop_q);
    if (push) beat_d = dtt_sat_inc(beat_q);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      beat_q <= '0;
    end else begin
      drop_q <= drop_d;
      beat_q <= beat_d;
    end
  end

  assign drop_count = drop_q;
  assign beat_count = beat_q;
`else
  assign drop_count = '0;
  assign beat_count = '0;
`endif

endmodule

// File: tb/tb_dtt_crossbar_egress.sv
// Randomised and directed bench for dtt_crossbar_egress.
// Reference model is a queue of beats plus drop/accept tallies.
module tb_dtt_crossbar_egress;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AF = DEPTH - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] xbar_data;
  logic          xbar_valid;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [2:0]    level;
  logic          almost_full;
  logic [15:0]   drop_count;
  logic [15:0]   beat_count;

  dtt_crossbar_egress #(
    .DATA_WIDTH   (DW),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .xbar_data   (xbar_data),
    .xbar_valid  (xbar_valid),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
    .almost_full (almost_full),
    .drop_count  (drop_count),
    .beat_count  (beat_count)
  );

  always #5 clk = ~clk;

  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  logic [DW-1:0] q[$];
  int unsigned   m_drops = 0;
  int unsigned   m_beats = 0;
  bit            stats_en;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int unsigned v);
    return (v > 32'hFFFF) ? 32'hFFFF : v;
  endfunction

  task automatic check_outputs();
    chk("m_valid", {31'b0, m_valid}, {31'b0, q.size() != 0});
    chk("level", {29'b0, level}, q.size());
    chk("almost_full", {31'b0, almost_full}, {31'b0, q.size() >= AF});
    if (q.size() != 0) chk("m_data", m_data, q[0]);
    chk("drop_count", {16'b0, drop_count}, stats_en ? sat(m_drops) : 0);
    chk("beat_count", {16'b0, beat_count}, stats_en ? sat(m_beats) : 0);
  endtask

  // Apply one cycle of inputs; model advances with the clock edge.
  task automatic step(input logic r, input logic v,
                      input logic [DW-1:0] d, input logic rd);
    bit popped;
    check_outputs();
    rst = r;
    xbar_valid = v;
    xbar_data = d;
    m_ready = rd;
    if (r) begin
      q.delete();
      m_drops = 0;
      m_beats = 0;
    end else begin
      popped = (q.size() != 0) && rd;
      if (popped) void'(q.pop_front());
      if (v) begin
        if (q.size() < DEPTH) begin
          q.push_back(d);
          m_beats++;
        end else begin
          m_drops++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
`ifdef DTT_EGRESS_STATS_EN
    stats_en = 1'b1;
`else
    stats_en = 1'b0;
`endif
    rst = 1'b1;
    xbar_valid = 1'b0;
    xbar_data = '0;
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step(1, 1, 32'hDEAD_BEEF, 0);

    // Single beat.
    step(0, 1, 32'hAAAA_BBBB, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Backpressure then drain.
    step(0, 1, 32'hCCCC_DDDD, 0);
    step(0, 1, 32'hEEEE_FFFF, 0);
    step(0, 1, 32'h1111_2222, 0);
    repeat (5) step(0, 0, 0, 1);

    // Overflow: six beats into four slots.
    for (int i = 0; i < 6; i++) step(0, 1, i, 0);
    step(0, 0, 0, 0);

    // Full with simultaneous push and pop.
    step(0, 1, 32'h5, 1);
    repeat (6) step(0, 0, 0, 1);

    // Mid-operation reset with a beat presented during reset.
    for (int i = 0; i < 3; i++) step(0, 1, 32'h100 + i, 0);
    step(1, 1, 32'h777, 1);
    step(0, 1, 32'h888, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom(),
           ($urandom_range(0, 2) != 0));
    end
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
